// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin arbiter/sequencer for the shared memory aligner
//
// Purpose: shares one aligner/RAM port between the MEM stage (port 0) and the
// AES loader (port 1). One request is latched at a time; aligner controls are
// held from the latched copy for the whole access; read data comes back with a
// registered one-cycle ack; a watchdog aborts accesses that stay busy too long.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   pX_req/we/vec/addr/wdata_s/v    requester X command (held until pX_ack)
//   pX_ack                          one-cycle completion pulse for port X
//   rd_scalar, rd_vector            registered read data, valid with the ack
//   stall0                          p0_req & ~p0_ack, MEM-stage stall
//   err, err_sticky                 abort pulse with ack / sticky abort flag
//   al_*  (out)                     aligner controls and operands, ACCESS only
//   al_busy, al_*DataOut (in)       aligner status and read data
module mem_port_arbiter #(
    parameter int N       = 32,
    parameter int V       = 256,
    parameter int TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           p0_req,
    input  logic           p0_we,
    input  logic           p0_vec,
    input  logic [31:0]    p0_addr,
    input  logic [15:0]    p0_wdata_s,
    input  logic [V-1:0]   p0_wdata_v,
    input  logic           p1_req,
    input  logic           p1_we,
    input  logic           p1_vec,
    input  logic [31:0]    p1_addr,
    input  logic [15:0]    p1_wdata_s,
    input  logic [V-1:0]   p1_wdata_v,
    output logic           p0_ack,
    output logic           p1_ack,
    output logic [N-1:0]   rd_scalar,
    output logic [V-1:0]   rd_vector,
    output logic           stall0,
    output logic           err,
    output logic           err_sticky,
    output logic           al_memtoRegM,
    output logic           al_memWriteM,
    output logic           al_memSrcM,
    output logic [31:0]    al_address,
    output logic [15:0]    al_scalarDataIn,
    output logic [V-1:0]   al_vectorDataIn,
    input  logic           al_busy,
    input  logic [N-1:0]   al_scalarDataOut,
    input  logic [V-1:0]   al_vectorDataOut
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Counter only has to reach TIMEOUT-1.
    localparam int CW = $clog2(TIMEOUT);

    logic [1:0]    state_q,      state_d;
    logic          last_grant_q, last_grant_d;
    logic          port_q,       port_d;
    logic          we_q,         we_d;
    logic          vec_q,        vec_d;
    logic [31:0]   addr_q,       addr_d;
    logic [15:0]   wdata_s_q,    wdata_s_d;
    logic [V-1:0]  wdata_v_q,    wdata_v_d;
    logic [CW-1:0] wait_cnt_q,   wait_cnt_d;
    logic          p0_ack_q,     p0_ack_d;
    logic          p1_ack_q,     p1_ack_d;
    logic          err_q,        err_d;
    logic          err_sticky_q, err_sticky_d;
    logic [N-1:0]  rd_scalar_q,  rd_scalar_d;
    logic [V-1:0]  rd_vector_q,  rd_vector_d;
    logic          sel1;
    logic          in_access;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        vec_d        = vec_q;
        addr_d       = addr_q;
        wdata_s_d    = wdata_s_q;
        wdata_v_d    = wdata_v_q;
        wait_cnt_d   = wait_cnt_q;
        p0_ack_d     = 1'b0;
        p1_ack_d     = 1'b0;
        err_d        = 1'b0;
        err_sticky_d = err_sticky_q;
        rd_scalar_d  = rd_scalar_q;
        rd_vector_d  = rd_vector_q;
        // Port 1 wins when alone, or when both ask and port 0 was granted last.
        sel1         = p1_req & (~p0_req | ~last_grant_q);

        case (state_q)
            ST_IDLE: begin
                if (p0_req | p1_req) begin
                    port_d       = sel1;
                    last_grant_d = sel1;
                    we_d         = sel1 ? p1_we      : p0_we;
                    vec_d        = sel1 ? p1_vec     : p0_vec;
                    addr_d       = sel1 ? p1_addr    : p0_addr;
                    wdata_s_d    = sel1 ? p1_wdata_s : p0_wdata_s;
                    wdata_v_d    = sel1 ? p1_wdata_v : p0_wdata_v;
                    wait_cnt_d   = '0;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!al_busy) begin
                    // Writes return zero data so stale reads never leak out.
                    rd_scalar_d = we_q ? '0 : al_scalarDataOut;
                    rd_vector_d = we_q ? '0 : al_vectorDataOut;
                    p0_ack_d    = ~port_q;
                    p1_ack_d    = port_q;
                    state_d     = ST_RESP;
                end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                    rd_scalar_d  = '0;
                    rd_vector_d  = '0;
                    p0_ack_d     = ~port_q;
                    p1_ack_d     = port_q;
                    err_d        = 1'b1;
                    err_sticky_d = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            vec_q        <= 1'b0;
            addr_q       <= '0;
            wdata_s_q    <= '0;
            wdata_v_q    <= '0;
            wait_cnt_q   <= '0;
            p0_ack_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            rd_scalar_q  <= '0;
            rd_vector_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            vec_q        <= vec_d;
            addr_q       <= addr_d;
            wdata_s_q    <= wdata_s_d;
            wdata_v_q    <= wdata_v_d;
            wait_cnt_q   <= wait_cnt_d;
            p0_ack_q     <= p0_ack_d;
            p1_ack_q     <= p1_ack_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            rd_scalar_q  <= rd_scalar_d;
            rd_vector_q  <= rd_vector_d;
        end
    end

    // Aligner sees a no-op outside ACCESS, so an async reset drops it at once.
    assign in_access       = (state_q == ST_ACCESS);
    assign al_memtoRegM    = in_access & ~we_q;
    assign al_memWriteM    = in_access & we_q;
    assign al_memSrcM      = in_access & vec_q;
    assign al_address      = in_access ? addr_q    : '0;
    assign al_scalarDataIn = in_access ? wdata_s_q : '0;
    assign al_vectorDataIn = in_access ? wdata_v_q : '0;

    assign p0_ack     = p0_ack_q;
    assign p1_ack     = p1_ack_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;
    assign rd_scalar  = rd_scalar_q;
    assign rd_vector  = rd_vector_q;
    assign stall0     = p0_req & ~p0_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int N = 32;
    localparam int V = 256;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic p0_req, p0_we, p0_vec, p1_req, p1_we, p1_vec;
    logic [31:0] p0_addr, p1_addr;
    logic [15:0] p0_wdata_s, p1_wdata_s;
    logic [V-1:0] p0_wdata_v, p1_wdata_v;
    logic p0_ack, p1_ack, stall0, err, err_sticky;
    logic [N-1:0] rd_scalar;
    logic [V-1:0] rd_vector;
    logic al_memtoRegM, al_memWriteM, al_memSrcM;
    logic [31:0] al_address;
    logic [15:0] al_scalarDataIn;
    logic [V-1:0] al_vectorDataIn;
    logic al_busy;
    logic [N-1:0] al_scalarDataOut;
    logic [V-1:0] al_vectorDataOut;

    mem_port_arbiter #(.N(N), .V(V), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_vec(p0_vec), .p0_addr(p0_addr),
        .p0_wdata_s(p0_wdata_s), .p0_wdata_v(p0_wdata_v),
        .p1_req(p1_req), .p1_we(p1_we), .p1_vec(p1_vec), .p1_addr(p1_addr),
        .p1_wdata_s(p1_wdata_s), .p1_wdata_v(p1_wdata_v),
        .p0_ack(p0_ack), .p1_ack(p1_ack), .rd_scalar(rd_scalar), .rd_vector(rd_vector),
        .stall0(stall0), .err(err), .err_sticky(err_sticky),
        .al_memtoRegM(al_memtoRegM), .al_memWriteM(al_memWriteM), .al_memSrcM(al_memSrcM),
        .al_address(al_address), .al_scalarDataIn(al_scalarDataIn),
        .al_vectorDataIn(al_vectorDataIn), .al_busy(al_busy),
        .al_scalarDataOut(al_scalarDataOut), .al_vectorDataOut(al_vectorDataOut)
    );

    // Aligner stand-in: byte RAM plus busy-cycle count by access type.
    logic [7:0] ram [0:255];
    logic force_busy;
    logic al_active;
    int acc_cyc;
    int need;

    always_comb begin
        al_active = al_memtoRegM | al_memWriteM;
        if (!al_memSrcM) need = al_memWriteM ? 0 : 1;
        else if (al_address[4:0] == 5'd0) need = al_memWriteM ? 0 : 1;
        else need = al_memWriteM ? 1 : 2;
        al_busy = force_busy | (al_active && (acc_cyc < need));
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            al_vectorDataOut[8*i +: 8] = ram[al_address[7:0] + 8'(i)];
        end
        for (int i = 0; i < 4; i++) begin
            al_scalarDataOut[8*i +: 8] = ram[al_address[7:0] + 8'(i)];
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) acc_cyc <= 0;
        else if (!al_active) acc_cyc <= 0;
        else acc_cyc <= acc_cyc + 1;
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
            ram[8'h40] <= 8'hEF; ram[8'h41] <= 8'hBE; ram[8'h42] <= 8'hAD; ram[8'h43] <= 8'hDE;
            ram[8'h80] <= 8'h78; ram[8'h81] <= 8'h56; ram[8'h82] <= 8'h34; ram[8'h83] <= 8'h12;
        end else if (al_memWriteM && !al_busy) begin
            if (al_memSrcM) begin
                for (int i = 0; i < 32; i++) ram[al_address[7:0] + 8'(i)] <= al_vectorDataIn[8*i +: 8];
            end else begin
                ram[al_address[7:0]]        <= al_scalarDataIn[7:0];
                ram[al_address[7:0] + 8'd1] <= al_scalarDataIn[15:8];
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int ack_cyc;
    logic got_port, got_err;
    logic [N-1:0] got_s;
    logic [V-1:0] got_v;
    logic [15:0] r_mtr, r_mwr, r_src, r_st0;
    localparam logic [V-1:0] PAT =
        256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;

    task automatic idle_inputs;
        p0_req = 0; p0_we = 0; p0_vec = 0; p0_addr = '0; p0_wdata_s = '0; p0_wdata_v = '0;
        p1_req = 0; p1_we = 0; p1_vec = 0; p1_addr = '0; p1_wdata_s = '0; p1_wdata_v = '0;
    endtask

    task automatic set_req(input int port, input logic we, input logic vec,
                           input logic [31:0] addr, input logic [15:0] ws, input logic [V-1:0] wv);
        if (port == 0) begin
            p0_req = 1; p0_we = we; p0_vec = vec; p0_addr = addr; p0_wdata_s = ws; p0_wdata_v = wv;
        end else begin
            p1_req = 1; p1_we = we; p1_vec = vec; p1_addr = addr; p1_wdata_s = ws; p1_wdata_v = wv;
        end
    endtask

    task automatic do_reset;
        reset = 1;
        idle_inputs();
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
    endtask

    // Called right after a rising edge (cycle 0 starts); returns at the ack cycle.
    task automatic run_until_ack(input int drop_port, input int drop_at, input int maxc);
        ack_cyc = -1; got_port = 0; got_err = 0; got_s = '0; got_v = '0;
        r_mtr = '0; r_mwr = '0; r_src = '0; r_st0 = '0;
        for (int c = 0; c <= maxc; c++) begin
            if (c == drop_at) begin
                if (drop_port == 0) p0_req = 0; else p1_req = 0;
            end
            @(negedge clk);
            r_mtr[c] = al_memtoRegM; r_mwr[c] = al_memWriteM;
            r_src[c] = al_memSrcM;   r_st0[c] = stall0;
            if (p0_ack | p1_ack) begin
                ack_cyc = c; got_port = p1_ack; got_err = err;
                got_s = rd_scalar; got_v = rd_vector;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic end_txn;
        @(posedge clk); #1;
        p0_req = 0; p1_req = 0;
    endtask

    task automatic test_reset;
        force_busy = 0;
        reset = 1;
        idle_inputs();
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        checks++; if (p0_ack !== 1'b0) begin errors++; $display("FAIL reset_p0_ack got %b want 0", p0_ack); end
        checks++; if (p1_ack !== 1'b0) begin errors++; $display("FAIL reset_p1_ack got %b want 0", p1_ack); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err_sticky got %b want 0", err_sticky); end
        checks++; if (rd_scalar !== '0) begin errors++; $display("FAIL reset_rd_scalar got %h want 0", rd_scalar); end
        checks++; if ({al_memtoRegM, al_memWriteM, al_memSrcM} !== 3'b000) begin errors++;
            $display("FAIL reset_al_ctrl got %b want 000", {al_memtoRegM, al_memWriteM, al_memSrcM}); end
        p0_req = 1; #1;
        checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL reset_stall0 got %b want 1", stall0); end
        p0_req = 0;
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic test_scalar_read;
        set_req(0, 0, 0, 32'h40, '0, '0);
        run_until_ack(-1, -1, 15);
        end_txn();
        checks++; if (ack_cyc !== 3) begin errors++; $display("FAIL sread_ack_cycle got %0d want 3", ack_cyc); end
        checks++; if (got_port !== 1'b0) begin errors++; $display("FAIL sread_port got %b want 0", got_port); end
        checks++; if (got_s !== 32'hDEADBEEF) begin errors++; $display("FAIL sread_data got %h want deadbeef", got_s); end
        checks++; if (r_mtr[3:0] !== 4'b0110) begin errors++; $display("FAIL sread_memtoreg got %b want 0110", r_mtr[3:0]); end
        checks++; if (r_st0[3:0] !== 4'b0111) begin errors++; $display("FAIL sread_stall0 got %b want 0111", r_st0[3:0]); end
    endtask

    task automatic test_scalar_write;
        set_req(0, 1, 0, 32'h60, 16'hBEEF, '0);
        run_until_ack(-1, -1, 15);
        end_txn();
        checks++; if (ack_cyc !== 2) begin errors++; $display("FAIL swrite_ack_cycle got %0d want 2", ack_cyc); end
        checks++; if (r_mwr[2:0] !== 3'b010) begin errors++; $display("FAIL swrite_memwrite got %b want 010", r_mwr[2:0]); end
        set_req(0, 0, 0, 32'h60, '0, '0);
        run_until_ack(-1, -1, 15);
        end_txn();
        checks++; if (got_s !== 32'h3938BEEF) begin errors++; $display("FAIL swrite_readback got %h want 3938beef", got_s); end
    endtask

    task automatic test_arbitration;
        int lc[4];
        logic lp[4];
        logic [31:0] ld[4];
        int nack;
        int exp_c[4];
        logic exp_p[4];
        logic [31:0] exp_d[4];
        exp_c = '{3, 7, 11, 15};
        exp_p = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_d = '{32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678};
        nack = 0;
        r_st0 = '0;
        do_reset();
        set_req(0, 0, 0, 32'h40, '0, '0);
        set_req(1, 0, 0, 32'h80, '0, '0);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            r_st0[c] = stall0;
            if (p0_ack | p1_ack) begin
                if (nack < 4) begin lc[nack] = c; lp[nack] = p1_ack; ld[nack] = rd_scalar; end
                nack++;
            end
            @(posedge clk); #1;
        end
        p0_req = 0; p1_req = 0;
        checks++; if (nack !== 4) begin errors++; $display("FAIL arb_ack_count got %0d want 4", nack); end
        for (int k = 0; k < 4 && k < nack; k++) begin
            checks++; if (lc[k] !== exp_c[k]) begin errors++; $display("FAIL arb_cycle[%0d] got %0d want %0d", k, lc[k], exp_c[k]); end
            checks++; if (lp[k] !== exp_p[k]) begin errors++; $display("FAIL arb_port[%0d] got %b want %b", k, lp[k], exp_p[k]); end
            checks++; if (ld[k] !== exp_d[k]) begin errors++; $display("FAIL arb_data[%0d] got %h want %h", k, ld[k], exp_d[k]); end
        end
        checks++; if (r_st0[7:0] !== 8'hF7) begin errors++; $display("FAIL arb_stall0 got %h want f7", r_st0[7:0]); end
    endtask

    task automatic test_unaligned_read;
        logic [V-1:0] exp_v;
        for (int i = 0; i < 32; i++) exp_v[8*i +: 8] = (8'h10 + 8'(i)) ^ 8'h5A;
        set_req(1, 0, 1, 32'h10, '0, '0);
        run_until_ack(1, 2, 15);
        end_txn();
        checks++; if (ack_cyc !== 4) begin errors++; $display("FAIL uread_ack_cycle got %0d want 4", ack_cyc); end
        checks++; if (got_port !== 1'b1) begin errors++; $display("FAIL uread_port got %b want 1", got_port); end
        checks++; if (got_v !== exp_v) begin errors++; $display("FAIL uread_data got %h want %h", got_v, exp_v); end
        checks++; if (r_src[3:0] !== 4'b1110) begin errors++; $display("FAIL uread_memsrc got %b want 1110", r_src[3:0]); end
    endtask

    task automatic test_vector_write;
        set_req(1, 1, 1, 32'h23, '0, PAT);
        run_until_ack(-1, -1, 15);
        end_txn();
        checks++; if (ack_cyc !== 3) begin errors++; $display("FAIL vwrite_ack_cycle got %0d want 3", ack_cyc); end
        checks++; if ({r_mwr[3:0], r_src[3:0]} !== 8'h66) begin errors++;
            $display("FAIL vwrite_ctrl got %b/%b want 0110/0110", r_mwr[3:0], r_src[3:0]); end
        checks++; if (r_mtr[3:0] !== 4'b0000) begin errors++; $display("FAIL vwrite_memtoreg got %b want 0000", r_mtr[3:0]); end
        set_req(0, 0, 1, 32'h23, '0, '0);
        run_until_ack(-1, -1, 15);
        end_txn();
        checks++; if (ack_cyc !== 4) begin errors++; $display("FAIL vreadback_ack_cycle got %0d want 4", ack_cyc); end
        checks++; if (got_v !== PAT) begin errors++; $display("FAIL vreadback_data got %h want %h", got_v, PAT); end
    endtask

    task automatic test_timeout;
        force_busy = 1;
        set_req(0, 0, 0, 32'h40, '0, '0);
        run_until_ack(-1, -1, 15);
        end_txn();
        force_busy = 0;
        checks++; if (ack_cyc !== TIMEOUT + 1) begin errors++; $display("FAIL tmo_ack_cycle got %0d want %0d", ack_cyc, TIMEOUT + 1); end
        checks++; if (got_err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b want 1", got_err); end
        checks++; if (got_s !== '0) begin errors++; $display("FAIL tmo_rd_scalar got %h want 0", got_s); end
        @(negedge clk);
        checks++; if ({err, err_sticky, p0_ack} !== 3'b010) begin errors++;
            $display("FAIL tmo_after got err/sticky/ack %b want 010", {err, err_sticky, p0_ack}); end
        @(posedge clk); #1;
        set_req(1, 0, 0, 32'h80, '0, '0);
        run_until_ack(-1, -1, 15);
        end_txn();
        checks++; if (got_s !== 32'h12345678) begin errors++; $display("FAIL tmo_next_data got %h want 12345678", got_s); end
        checks++; if ({got_err, err_sticky} !== 2'b01) begin errors++;
            $display("FAIL tmo_sticky got err/sticky %b want 01", {got_err, err_sticky}); end
    endtask

    task automatic test_reset_mid;
        int stray;
        stray = 0;
        set_req(1, 0, 1, 32'h10, '0, '0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset = 1;
        #1;
        checks++; if ({al_memtoRegM, al_memSrcM, p1_ack} !== 3'b000) begin errors++;
            $display("FAIL rmid_ctrl got %b want 000", {al_memtoRegM, al_memSrcM, p1_ack}); end
        checks++; if (al_address !== 32'h0) begin errors++; $display("FAIL rmid_addr got %h want 0", al_address); end
        checks++; if ({err_sticky, rd_scalar} !== 33'h0) begin errors++;
            $display("FAIL rmid_regs got sticky %b rd %h want 0", err_sticky, rd_scalar); end
        p1_req = 0;
        @(posedge clk); #1;
        reset = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (p0_ack | p1_ack) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL rmid_no_ack got %0d acks want 0", stray); end
        @(posedge clk); #1;
        set_req(0, 0, 0, 32'h80, '0, '0);
        run_until_ack(-1, -1, 15);
        end_txn();
        checks++; if (ack_cyc !== 3) begin errors++; $display("FAIL rmid_next_cycle got %0d want 3", ack_cyc); end
        checks++; if (got_s !== 32'h12345678) begin errors++; $display("FAIL rmid_next_data got %h want 12345678", got_s); end
    endtask

    initial begin
        force_busy = 0;
        reset = 1;
        idle_inputs();
        test_reset();
        test_scalar_read();
        test_scalar_write();
        test_arbitration();
        test_unaligned_read();
        test_vector_write();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer in front of the 256-bit memory data aligner. It shares the single aligner/RAM port between the pipeline MEM stage (port 0) and the AES data/key loader (port 1). It latches one request at a time, holds the aligner controls stable for the whole multi-cycle access, returns read data through a registered ack, and aborts hung accesses with a watchdog.

## Interface
- N, 32: scalar read data width
- V, 256: vector data width
- TIMEOUT, 8: max ACCESS cycles before abort (≥4)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- pX_req  in  1  port X request (X = 0,1), held until pX_ack
- pX_we  in  1  1 = write, 0 = read
- pX_vec  in  1  1 = vector (V bits), 0 = scalar
- pX_addr  in  32  byte address
- pX_wdata_s  in  16  scalar write data
- pX_wdata_v  in  V  vector write data
- pX_ack  out  1  one-cycle completion pulse for port X
- rd_scalar  out  N  registered read data, valid while ack high
- rd_vector  out  V  registered read data, valid while ack high
- stall0  out  1  p0_req & ~p0_ack (MEM-stage stall to hazard unit)
- err  out  1  one-cycle pulse with an aborted ack
- err_sticky  out  1  set on any abort, cleared only by reset
- al_memtoRegM, al_memWriteM, al_memSrcM  out  1 each  aligner controls
- al_address  out  32; al_scalarDataIn  out  16; al_vectorDataIn  out  V  aligner operands
- al_busy  in  1  aligner busy
- al_scalarDataOut  in  N; al_vectorDataOut  in  V  aligner read data

## Operation
- States: IDLE, ACCESS, RESP. Reset: IDLE, last_grant=1, all outputs 0, latched request and data registers 0.
- IDLE: if any req, pick winner, latch its we/vec/addr/wdata and port id, go ACCESS. Only one req: it wins. Both: port ≠ last_grant wins, so port 0 wins first after reset. Round-robin updates last_grant on grant.
- ACCESS: aligner controls driven from latched registers only (al_memtoRegM=~we, al_memWriteM=we, al_memSrcM=vec). Outside ACCESS all al_* outputs are 0, so aligner sees no op and stays ready.
- ACCESS exit on the rising edge where al_busy=0: latch al_scalarDataOut/al_vectorDataOut (reads), or 0 (writes), go RESP.
- Watchdog: wait counter cleared on ACCESS entry, +1 per ACCESS cycle with al_busy=1. If counter = TIMEOUT-1 and al_busy=1: go RESP with abort flag, read data forced 0.
- RESP: assert pX_ack for latched port for exactly one cycle, plus err if aborted. Then IDLE.
- Requester inputs change or req drop during ACCESS/RESP: ignored (values latched). Req high in the cycle after its ack counts as a new request.
- Reset asserted mid-ACCESS: immediate return to IDLE, no ack, controls 0. The aligner shares reset, so its counter also clears.

## Timing
- Cycle 0 = IDLE cycle with req sampled. ACCESS starts cycle 1. Ack cycle = 2 + number of ACCESS cycles with al_busy=1.
- Against the aligner:
  - Scalar write: ack cycle 2.
  - Scalar read, aligned vector read, unaligned vector write: ack cycle 3.
  - Aligned vector write: ack cycle 2.
  - Unaligned vector read: ack cycle 4.
- Back-to-back: minimum 3 cycles per transaction (IDLE, ACCESS, RESP). A pending loser is granted in the IDLE after RESP.
- stall0 is combinational from p0_req and registered p0_ack. Other outputs are registered, except al_*, which decode from state and latched registers.
- Abort: ack and err in cycle TIMEOUT+1.

## Test plan
- Reset then p0 scalar read addr 0x40, RAM word 0xDEADBEEF → al_memtoRegM high cycles 1–2, p0_ack cycle 3, rd_scalar=0xDEADBEEF, stall0 high cycles 0–2.
- p1 vector write addr 0x23, data pattern → al_memWriteM/al_memSrcM high cycles 1–2, p1_ack cycle 3, RAM readback equals pattern across blocks 1–2.
- p0 and p1 req together, both held, after reset → p0 acked first, then p1 granted in the following IDLE. Repeat: grants alternate 0,1,0,1.
- p1 unaligned vector read addr 0x10 → p1_ack cycle 4, rd_vector = 32 bytes from 0x10. Drop p1_req in cycle 2: transaction still completes.
- Force al_busy=1 with TIMEOUT=8 → ack and err in cycle 9, rd data 0, err_sticky stays 1 until reset.
- Assert reset in cycle 2 of an unaligned read → all outputs 0 asynchronously, no ack. The next request after reset is served normally.
